// File: rtl/updown_pkg.sv
// Shared definitions for the parametrised up/down counter: mode constants,
// the decoded step encoding and the parameter legality check.
package updown_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'b00,
        STEP_UP   = 2'b01,
        STEP_DOWN = 2'b10
    } step_t;

    // True when the parameter set describes a buildable counter.
    function automatic bit params_legal(input int width, input longint max_count,
                                        input int saturate, input longint reset_value);
        longint limit;
        if (width < 2 || width > 62) begin
            return 1'b0;
        end
        limit = (longint'(1) << width) - 1;
        return (max_count >= 1) && (max_count <= limit) &&
               (saturate == MODE_WRAP || saturate == MODE_SAT) &&
               (reset_value >= 0) && (reset_value <= max_count);
    endfunction

endpackage

// File: rtl/updown_counter_param_if.sv
// Bus bundle between a controller and the up/down counter: request strobes
// flow toward the counter, the registered count and status flow back.
interface updown_counter_param_if #(
    parameter int WIDTH = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             increment;
    logic             decrement;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_min;
    logic             wrap_pulse;
    logic             sat_pulse;
    logic             load_err;
    logic             dir;

    modport master (
        output clear, load, load_value, increment, decrement,
        input  count, at_max, at_min, wrap_pulse, sat_pulse, load_err, dir
    );

    modport slave (
        input  clear, load, load_value, increment, decrement,
        output count, at_max, at_min, wrap_pulse, sat_pulse, load_err, dir
    );
endinterface

// File: rtl/updown_next_calc.sv
// Combinational next-state logic of the up/down counter. Applies the
// clear > load > step priority and reports which event the update caused.
module updown_next_calc
    import updown_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MAX_COUNT   = (1 << WIDTH) - 1,
    parameter int SATURATE    = MODE_WRAP,
    parameter int RESET_VALUE = 0
) (
    input  logic [WIDTH-1:0] count,
    input  step_t            step,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dir,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_evt,
    output logic             sat_evt,
    output logic             lerr_evt,
    output logic             next_dir
);

    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VALUE);

    // Limits are compared before stepping, so count never leaves 0..MAX_COUNT
    // and no carry bit is needed.
    always_comb begin
        next_count = count;
        wrap_evt   = 1'b0;
        sat_evt    = 1'b0;
        lerr_evt   = 1'b0;
        next_dir   = dir;
        if (clear) begin
            next_count = RESET_VAL;
        end else if (load) begin
            if (load_value > MAX_VAL) begin
                next_count = MAX_VAL;
                lerr_evt   = 1'b1;
            end else begin
                next_count = load_value;
            end
        end else begin
            case (step)
                STEP_UP: begin
                    next_dir = 1'b1;
                    if (count == MAX_VAL) begin
                        if (SATURATE == MODE_SAT) begin
                            sat_evt = 1'b1;
                        end else begin
                            next_count = '0;
                            wrap_evt   = 1'b1;
                        end
                    end else begin
                        next_count = count + WIDTH'(1);
                    end
                end
                STEP_DOWN: begin
                    next_dir = 1'b0;
                    if (count == '0) begin
                        if (SATURATE == MODE_SAT) begin
                            sat_evt = 1'b1;
                        end else begin
                            next_count = MAX_VAL;
                            wrap_evt   = 1'b1;
                        end
                    end else begin
                        next_count = count - WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap or saturate behaviour, synchronous
// clear/load and registered one-cycle event flags.
module updown_counter_param
    import updown_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MAX_COUNT   = (1 << WIDTH) - 1,
    parameter int SATURATE    = MODE_WRAP,
    parameter int RESET_VALUE = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    updown_counter_param_if.slave  bus
);

    localparam bit               PARAMS_OK = params_legal(WIDTH, longint'(MAX_COUNT),
                                                          SATURATE, longint'(RESET_VALUE));
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VALUE);

    if (!PARAMS_OK) begin : g_bad_params
        $fatal(1, "updown_counter_param: illegal WIDTH/MAX_COUNT/SATURATE/RESET_VALUE");
    end

    step_t            step;
    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             sat_q;
    logic             lerr_q;
    logic             dir_q;
    logic [WIDTH-1:0] next_count;
    logic             wrap_evt;
    logic             sat_evt;
    logic             lerr_evt;
    logic             next_dir;

    // Both or neither strobe means hold; only a lone strobe moves the count.
    always_comb begin
        step = STEP_HOLD;
        if (bus.increment && !bus.decrement) begin
            step = STEP_UP;
        end else if (bus.decrement && !bus.increment) begin
            step = STEP_DOWN;
        end
    end

    updown_next_calc #(
        .WIDTH       (WIDTH),
        .MAX_COUNT   (MAX_COUNT),
        .SATURATE    (SATURATE),
        .RESET_VALUE (RESET_VALUE)
    ) u_next_calc (
        .count      (count_q),
        .step       (step),
        .clear      (bus.clear),
        .load       (bus.load),
        .load_value (bus.load_value),
        .dir        (dir_q),
        .next_count (next_count),
        .wrap_evt   (wrap_evt),
        .sat_evt    (sat_evt),
        .lerr_evt   (lerr_evt),
        .next_dir   (next_dir)
    );

    // Count, direction and event flags all update on the same edge so the
    // pulses line up with the count they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= RESET_VAL;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
            lerr_q  <= 1'b0;
            dir_q   <= 1'b1;
        end else begin
            count_q <= next_count;
            wrap_q  <= wrap_evt;
            sat_q   <= sat_evt;
            lerr_q  <= lerr_evt;
            dir_q   <= next_dir;
        end
    end

    assign bus.count      = count_q;
    assign bus.at_max     = (count_q == MAX_VAL);
    assign bus.at_min     = (count_q == '0);
    assign bus.wrap_pulse = wrap_q;
    assign bus.sat_pulse  = sat_q;
    assign bus.load_err   = lerr_q;
    assign bus.dir        = dir_q;

endmodule
